// File: rtl/seq_fsm_selfcorrect_pkg.sv
// Shared constants, step-action encoding and parameter check for the
// self-correcting sequence counter and its seven-segment display.
package seq_fsm_selfcorrect_pkg;

  typedef enum logic [1:0] {
    ACT_HOLD    = 2'd0,
    ACT_STEP    = 2'd1,
    ACT_RECOVER = 2'd2,
    ACT_LOAD    = 2'd3
  } step_act_e;

  // Active-low segments, bit order {g,f,e,d,c,b,a}; index is the hex digit.
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam logic [6:0] SEG_DASH = 7'h3F;

  function automatic bit params_ok(int width, int seq_len);
    return (width >= 2) && (width <= 4) && (seq_len >= 2) && (seq_len <= (1 << width));
  endfunction

endpackage

// File: rtl/seq_fsm_selfcorrect_if.sv
// Control inputs and status/display outputs of the sequence counter.
interface seq_fsm_selfcorrect_if #(
  parameter int WIDTH = 3,
  parameter int ERR_W = 8
);
  logic             x;
  logic             en;
  logic             force_en;
  logic [WIDTH-1:0] force_val;
  logic [WIDTH-1:0] state;
  logic             recover;
  logic [ERR_W-1:0] err_count;
  logic             seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g;

  modport master (
    output x, en, force_en, force_val,
    input  state, recover, err_count,
    input  seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g
  );

  modport slave (
    input  x, en, force_en, force_val,
    output state, recover, err_count,
    output seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g
  );
endinterface

// File: rtl/seq_fsm_selfcorrect_seg7_hex_decode.sv
// Combinational hex-to-seven-segment decoder, active-low, with a dash for
// values flagged illegal.
module seg7_hex_decode
  import seq_fsm_selfcorrect_pkg::*;
(
  input  logic [3:0] value,
  input  logic       illegal,
  output logic [6:0] seg
);

  always_comb begin
    seg = illegal ? SEG_DASH : SEG_HEX[value];
  end

endmodule

// File: rtl/seq_fsm_selfcorrect.sv
// Self-correcting up/down sequence counter with fault-injection load,
// saturating recovery counter and registered seven-segment output.
//
// action      | meaning
// ACT_LOAD    | force_en high: load force_val, legal or not
// ACT_RECOVER | state >= SEQ_LEN: go to 0, pulse recover, count it
// ACT_STEP    | en high: step up (x=1) or down (x=0), wrapping
// ACT_HOLD    | keep the current state
module seq_fsm_selfcorrect
  import seq_fsm_selfcorrect_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int SEQ_LEN = 6,
  parameter int ERR_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  seq_fsm_selfcorrect_if.slave bus
);

  if (!params_ok(WIDTH, SEQ_LEN)) begin : g_param_check
    $error("seq_fsm_selfcorrect: need 2<=WIDTH<=4 and 2<=SEQ_LEN<=2**WIDTH");
  end

  localparam logic [WIDTH:0]   SEQ_LEN_W = (WIDTH+1)'(SEQ_LEN);
  localparam logic [WIDTH-1:0] LAST      = WIDTH'(SEQ_LEN - 1);

  logic [WIDTH-1:0] state_q, state_d;
  logic             recover_q, recover_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [6:0]       seg_q, seg_d;
  logic [6:0]       dec_seg;
  logic             illegal;
  step_act_e        act;

  // Always false when SEQ_LEN fills the whole state space.
  assign illegal = ({1'b0, state_q} >= SEQ_LEN_W);

  always_comb begin
    act = ACT_HOLD;
    if (bus.force_en) begin
      act = ACT_LOAD;
    end else if (illegal) begin
      act = ACT_RECOVER;
    end else if (bus.en) begin
      act = ACT_STEP;
    end
  end

  always_comb begin
    state_d   = state_q;
    recover_d = 1'b0;
    err_d     = err_q;
    case (act)
      ACT_LOAD: begin
        state_d = bus.force_val;
      end
      ACT_RECOVER: begin
        state_d   = '0;
        recover_d = 1'b1;
        err_d     = (err_q == '1) ? err_q : err_q + ERR_W'(1);
      end
      ACT_STEP: begin
        if (bus.x) begin
          state_d = (state_q == LAST) ? '0 : state_q + WIDTH'(1);
        end else begin
          state_d = (state_q == '0) ? LAST : state_q - WIDTH'(1);
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  seg7_hex_decode u_dec (
    .value   (4'(state_q)),
    .illegal (illegal),
    .seg     (dec_seg)
  );

  assign seg_d = dec_seg;

  // Segments load the "0" pattern directly on reset rather than one cycle later.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= '0;
      recover_q <= 1'b0;
      err_q     <= '0;
      seg_q     <= SEG_HEX[0];
    end else begin
      state_q   <= state_d;
      recover_q <= recover_d;
      err_q     <= err_d;
      seg_q     <= seg_d;
    end
  end

  assign bus.state     = state_q;
  assign bus.recover   = recover_q;
  assign bus.err_count = err_q;
  assign bus.seg_a     = seg_q[0];
  assign bus.seg_b     = seg_q[1];
  assign bus.seg_c     = seg_q[2];
  assign bus.seg_d     = seg_q[3];
  assign bus.seg_e     = seg_q[4];
  assign bus.seg_f     = seg_q[5];
  assign bus.seg_g     = seg_q[6];

endmodule

// File: tb/tb_seq_fsm_selfcorrect.sv
// Directed bench for seq_fsm_selfcorrect across three parameter sets.
module tb_seq_fsm_selfcorrect;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  seq_fsm_selfcorrect_if #(.WIDTH(3), .ERR_W(8)) ia ();
  seq_fsm_selfcorrect_if #(.WIDTH(3), .ERR_W(2)) ib ();
  seq_fsm_selfcorrect_if #(.WIDTH(2), .ERR_W(8)) ic ();

  seq_fsm_selfcorrect #(.WIDTH(3), .SEQ_LEN(6), .ERR_W(8)) u_a (.clk(clk), .reset(reset), .bus(ia));
  seq_fsm_selfcorrect #(.WIDTH(3), .SEQ_LEN(6), .ERR_W(2)) u_b (.clk(clk), .reset(reset), .bus(ib));
  seq_fsm_selfcorrect #(.WIDTH(2), .SEQ_LEN(4), .ERR_W(8)) u_c (.clk(clk), .reset(reset), .bus(ic));

  // Standard active-high a-g patterns {g..a}; the bench inverts them.
  localparam logic [6:0] HEX_ON [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic [6:0] a_seg, b_seg, c_seg;
  assign a_seg = {ia.seg_g, ia.seg_f, ia.seg_e, ia.seg_d, ia.seg_c, ia.seg_b, ia.seg_a};
  assign b_seg = {ib.seg_g, ib.seg_f, ib.seg_e, ib.seg_d, ib.seg_c, ib.seg_b, ib.seg_a};
  assign c_seg = {ic.seg_g, ic.seg_f, ic.seg_e, ic.seg_d, ic.seg_c, ic.seg_b, ic.seg_a};

  function automatic logic [6:0] exp_seg(int d);
    if (d < 0) return 7'b0111111;
    return ~HEX_ON[d];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // e_sd: digit shown on the display, -1 for the dash.
  task automatic chk_all(string tag, logic [3:0] st, logic [6:0] sg, logic rc, logic [7:0] er,
                         int e_st, int e_sd, logic e_rc, int e_er);
    chk({tag, ".state"}, 32'(st), 32'(e_st));
    chk({tag, ".seg"}, 32'(sg), 32'(exp_seg(e_sd)));
    chk({tag, ".recover"}, 32'(rc), 32'(e_rc));
    chk({tag, ".err"}, 32'(er), 32'(e_er));
  endtask

  task automatic chk_a(string tag, int e_st, int e_sd, logic e_rc, int e_er);
    chk_all(tag, 4'(ia.state), a_seg, ia.recover, ia.err_count, e_st, e_sd, e_rc, e_er);
  endtask

  task automatic chk_b(string tag, int e_st, int e_sd, logic e_rc, int e_er);
    chk_all(tag, 4'(ib.state), b_seg, ib.recover, 8'(ib.err_count), e_st, e_sd, e_rc, e_er);
  endtask

  task automatic chk_c(string tag, int e_st, int e_sd, logic e_rc, int e_er);
    chk_all(tag, 4'(ic.state), c_seg, ic.recover, ic.err_count, e_st, e_sd, e_rc, e_er);
  endtask

  initial begin
    int st;
    int prev;
    reset = 1'b0;
    ia.x = 1'b1; ia.en = 1'b1; ia.force_en = 1'b0; ia.force_val = '0;
    ib.x = 1'b1; ib.en = 1'b0; ib.force_en = 1'b0; ib.force_val = '0;
    ic.x = 1'b1; ic.en = 1'b0; ic.force_en = 1'b0; ic.force_val = '0;
    tick();
    tick();
    chk_a("a_reset", 0, 0, 1'b0, 0);
    chk_b("b_reset", 0, 0, 1'b0, 0);
    chk_c("c_reset", 0, 0, 1'b0, 0);

    reset = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk_a("a_up", i % 6, i - 1, 1'b0, 0);
    end

    ia.x = 1'b0;
    st = 0;
    prev = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      st = (st == 0) ? 5 : st - 1;
      chk_a("a_down", st, prev, 1'b0, 0);
      prev = st;
    end

    ia.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_a("a_hold", 5, 5, 1'b0, 0);
    end

    ia.force_val = 3'd7;
    ia.force_en = 1'b1;
    tick();
    chk_a("a_force7", 7, 5, 1'b0, 0);
    ia.force_en = 1'b0;
    tick();
    chk_a("a_recover7", 0, -1, 1'b1, 1);
    tick();
    chk_a("a_after7", 0, 0, 1'b0, 1);

    ia.force_val = 3'd6;
    ia.force_en = 1'b1;
    ia.en = 1'b1;
    ia.x = 1'b1;
    tick();
    chk_a("a_hold6_0", 6, 0, 1'b0, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_a("a_hold6", 6, -1, 1'b0, 1);
    end
    ia.force_en = 1'b0;
    tick();
    chk_a("a_recover6", 0, -1, 1'b1, 2);
    tick();
    chk_a("a_after6", 1, 0, 1'b0, 2);
    ia.en = 1'b0;

    for (int k = 1; k <= 5; k++) begin
      ib.force_val = (k % 2 == 1) ? 3'd7 : 3'd6;
      ib.force_en = 1'b1;
      tick();
      chk_b("b_load", (k % 2 == 1) ? 7 : 6, 0, 1'b0, (k - 1 > 3) ? 3 : k - 1);
      ib.force_en = 1'b0;
      tick();
      chk_b("b_sat", 0, -1, 1'b1, (k > 3) ? 3 : k);
    end

    ic.force_val = 2'd3;
    ic.force_en = 1'b1;
    tick();
    chk_c("c_load3", 3, 0, 1'b0, 0);
    ic.force_en = 1'b0;
    ic.en = 1'b1;
    ic.x = 1'b1;
    tick();
    chk_c("c_wrap", 0, 3, 1'b0, 0);
    tick();
    chk_c("c_step1", 1, 0, 1'b0, 0);
    tick();
    chk_c("c_step2", 2, 1, 1'b0, 0);

    reset = 1'b0;
    tick();
    chk_c("c_midreset", 0, 0, 1'b0, 0);
    chk_a("a_midreset", 0, 0, 1'b0, 0);
    reset = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_fsm_selfcorrect.md
# seq_fsm_selfcorrect

Parametrised self-correcting sequence state machine with a direction input, step enable, fault-injection load port and a registered active-low seven-segment display output. It is the generalised successor of the fixed 3-bit self-correcting counter/display block. It sits between board-level push-button/switch logic and a single common-anode seven-segment digit. Illegal states are always recovered in one clock and counted, so recovery can be observed in lab and in simulation.

## Interface
- WIDTH, 3: state register width; legal range 2..4.
- SEQ_LEN, 6: number of legal states, 0..SEQ_LEN-1; legal range 2..2**WIDTH.
- ERR_W, 8: width of the saturating recovery counter.

- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low reset, sampled on rising clk.
- x  in  1  direction: 1 = count up, 0 = count down.
- en  in  1  step enable; 0 holds the current legal state.
- force_en  in  1  fault-injection load strobe.
- force_val  in  WIDTH  value loaded when force_en=1; may be illegal.
- state  out  WIDTH  current state register.
- recover  out  1  one-cycle pulse: an illegal state was corrected on the previous edge.
- err_count  out  ERR_W  number of recoveries since reset, saturating.
- seg_a..seg_g  out  1 each  segment drives, active-low (0 = lit), registered.

## Operation
- Next-state priority on every rising clk: reset low > force_en > illegal recovery > en step > hold.
- reset low: state=0, recover=0, err_count=0, segments show "0" (seg_a..seg_f=0, seg_g=1).
- force_en=1: state<=force_val, including illegal values. recover is not asserted and err_count is not changed by the load itself.
- Illegal state (state >= SEQ_LEN, only possible via force): state<=0 regardless of en/x, recover<=1, err_count<=err_count+1 saturating at 2**ERR_W-1.
- Legal state with en=1:
  - x=1: state<=state+1, wrapping SEQ_LEN-1 -> 0.
  - x=0: state<=state-1, wrapping 0 -> SEQ_LEN-1.
- Legal state with en=0: state holds.
- recover is 0 in every cycle that is not immediately after a recovery edge.
- When SEQ_LEN == 2**WIDTH there are no illegal states: recover stays 0 and err_count stays 0.
- Display: segments encode the hex digit of state (0-F) using the standard a-g pattern. An illegal state shows a dash: only seg_g=0, all others 1.

## Timing
- state: updated on the edge where inputs are sampled, so the latency from x/en/force to state is 1 cycle.
- Segments: registered from state, so they lag state by exactly 1 cycle (2 cycles from the input).
- recover and err_count: both update on the same edge that writes state=0 out of an illegal state.
- Forced illegal value: visible on state for exactly one cycle, and on the segments as a dash for exactly one cycle, one cycle later.
- force_en held high on an illegal value: state reloads the illegal value every cycle and no recovery occurs. Recovery occurs on the first edge after force_en drops.
- Reset mid-sequence: on the first edge with reset low, state, recover and err_count clear. Segments show "0" on that same edge, not one cycle later.

## Structure
- Shared package holds:
  - the 16-entry active-low hex segment pattern constant;
  - the dash pattern constant;
  - the elaboration check WIDTH in 2..4 and 2 <= SEQ_LEN <= 2**WIDTH, which errors out otherwise.
- One sub-module, seg7_hex_decode: combinational, 4-bit value plus illegal flag in, 7 active-low segment bits out. The parent zero-extends state to 4 bits and registers the decoder outputs.
- The next-state logic, recovery counter and output registers stay in the parent.

## Test plan
- Reset low 2 cycles, then release with en=1, x=1 (defaults): state 0,1,2,3,4,5,0 on successive cycles. Segments follow one cycle later; after reset the first pattern is seg_a..f=0, seg_g=1.
- en=1, x=0 from state 0: state 5,4,3,2,1,0,5. en=0 for 3 cycles: state holds and recover=0.
- force_en=1 for one cycle with force_val=7: state=7 for one cycle, then 0. recover=1 for one cycle, err_count=1, segments show the dash for one cycle.
- force_en held high with force_val=6 for 4 cycles: state stays 6 and err_count is unchanged. On the edge after release, state=0 and err_count increments by 1.
- ERR_W=2, inject 5 illegal values: err_count goes 1,2,3,3,3.
- WIDTH=2, SEQ_LEN=4: force_val=3 is loaded, then steps to 0 with recover never asserted. Then assert reset low during counting: the next edge gives state=0 and err_count=0.
